sprite_fetch_scheduler: RTL and testbench
=========================================

SPRITE_FETCH_SCHEDULER -- requirements
Module: sprite_fetch_scheduler

Interface
REQ-001 The block SHALL have parameter N_LAYERS, default 4, meaning the number of sprite layers; layer 0 is highest priority.
REQ-002 The block SHALL have parameter SPR_DIM, default 32, meaning sprite width and height in pixels (power of two).
REQ-003 The block SHALL have parameter COORD_W, default 10, meaning the screen coordinate width.
REQ-004 The block SHALL have these ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; asynchronous, active-high.
- pix_start  in  1  one-cycle request to resolve one screen pixel.
- pix_x, pix_y  in  COORD_W  pixel coordinate, sampled with pix_start.
- cfg_we  in  1  layer-configuration write strobe.
- cfg_layer  in  2  layer index being written.
- cfg_en  in  1  layer enable value.
- cfg_x, cfg_y  in  COORD_W  sprite top-left position.
- bram_en  out  1  sprite BRAM read enable.
- bram_addr  out  12  {layer[1:0], yoff[4:0], xoff[4:0]}.
- bram_dout  in  4  palette index returned one cycle after bram_en.
- pix_index  out  4  resolved palette index for the colour decoder.
- pix_valid  out  1  one-cycle strobe qualifying pix_index.
- busy  out  1  high in every state other than IDLE.
- overrun  out  1  one-cycle pulse when pix_start is dropped.

Function
REQ-005 The FSM SHALL have states IDLE, SCAN, DRAIN and OUT.
REQ-006 A pix_start in IDLE at cycle T SHALL latch pix_x, pix_y and a snapshot of all layer configuration registers, then move to SCAN.
REQ-007 SCAN SHALL last exactly N_LAYERS cycles (T+1..T+4), evaluating layer k in cycle T+1+k.
REQ-008 Layer k SHALL hit when enabled, sx<=x<sx+SPR_DIM and sy<=y<sy+SPR_DIM, with comparisons computed at COORD_W+1 bits so that sx+SPR_DIM never wraps.
REQ-009 On a hit, the block SHALL assert bram_en with bram_addr={k, y-sy, x-sx}; otherwise bram_en SHALL be 0.
REQ-010 After an opaque result (nonzero index) has been captured, the block SHALL assert no further bram_en for that pixel (early-out).
REQ-011 Returned data SHALL be captured one cycle after its bram_en; the first captured nonzero value SHALL win and 0 SHALL be treated as transparent.
REQ-012 DRAIN SHALL last one cycle (T+5) and capture the final read.
REQ-013 OUT (T+6) SHALL assert pix_valid=1 with pix_index equal to the winner, or 0 if no layer was opaque, then return to IDLE.
REQ-014 Latency SHALL be fixed at 6 cycles from pix_start to pix_valid, independent of hits and early-out.
REQ-015 A pix_start received while busy=1 SHALL be ignored, SHALL pulse overrun for one cycle, and SHALL NOT disturb the pixel in flight.
REQ-016 A pix_start arriving in the OUT cycle SHALL count as busy; the minimum pix_start spacing is therefore 7 cycles.
REQ-017 A cfg_we write SHALL update the live configuration registers on the next clock edge in any state; the in-flight pixel SHALL continue to use its snapshot.
REQ-018 When cfg_we and pix_start coincide, the snapshot SHALL hold the pre-write values.
REQ-019 pix_index SHALL hold its value between pix_valid strobes.

Reset
REQ-020 Asserting rst SHALL, asynchronously and at any time, force state=IDLE.
REQ-021 Reset SHALL force bram_en=0, bram_addr=0, pix_index=0, pix_valid=0, busy=0 and overrun=0.
REQ-022 Reset SHALL clear all layer enables and positions to 0.
REQ-023 If reset occurs mid-pixel, the block SHALL produce no pix_valid for that pixel.

Structure
REQ-024 A shared package SHALL hold N_LAYERS, SPR_DIM, COORD_W, IDX_W=4, TRANSPARENT_IDX=0 and the FSM state encoding.
REQ-025 A combinational sub-module sprite_hit_check SHALL compute hit, xoff and yoff for one layer and be instantiated once per layer.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Layer 0 at (100,50) enabled, BRAM returns 3; pix_start at (110,60) -> bram_addr={0,10,10}, pix_valid at T+6 with pix_index=3, and only one bram_en.
- Layers 0 and 2 cover (200,200); layer 0 returns 0 and layer 2 returns 6 -> two reads, pix_index=6.
- No layer enabled; pix_start -> bram_en never asserted, pix_valid at T+6 with pix_index=0.
- pix_start at T and again at T+3 -> overrun pulse at T+3, exactly one pix_valid at T+6.
- Layer 1 at sx=620, pix_x=639 -> hit, xoff=19; pix_x=652 (beyond the 640-pixel visible width) -> no hit, and the comparison does not wrap.
- rst asserted at T+3 -> all outputs 0 immediately, and no pix_valid occurs.

Source files
------------

// File: rtl/sprite_fetch_scheduler_pkg.sv
// Shared constants for the sprite fetch scheduler.
// Holds the default geometry (layer count, sprite size, coordinate width),
// the palette index width, the transparent palette value and the FSM state
// encoding.  A small helper decides whether a palette index is opaque.
package sprite_fetch_scheduler_pkg;

    localparam int N_LAYERS = 4;
    localparam int SPR_DIM  = 32;
    localparam int COORD_W  = 10;
    localparam int IDX_W    = 4;
    localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 4'd0;

    // Width of the layer field inside the BRAM address and of the layer index.
    localparam int LAYER_W  = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // A palette index wins only if it is not the transparent value.
    function automatic logic is_opaque(input logic [IDX_W-1:0] idx);
        return (idx != TRANSPARENT_IDX);
    endfunction

endpackage

// File: rtl/sprite_fetch_scheduler_hit_check.sv
// sprite_hit_check: combinational hit test of one pixel against one sprite.
// Ports:
//   i_en         layer enable
//   i_sx, i_sy   sprite top-left corner
//   i_x, i_y     pixel coordinate being resolved
//   o_hit        pixel lies inside the enabled sprite
//   o_xoff/yoff  pixel offset inside the sprite (valid when o_hit)
module sprite_hit_check
    import sprite_fetch_scheduler_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int SPR_DIM = 32
) (
    input  logic                       i_en,
    input  logic [COORD_W-1:0]         i_sx,
    input  logic [COORD_W-1:0]         i_sy,
    input  logic [COORD_W-1:0]         i_x,
    input  logic [COORD_W-1:0]         i_y,
    output logic                       o_hit,
    output logic [$clog2(SPR_DIM)-1:0] o_xoff,
    output logic [$clog2(SPR_DIM)-1:0] o_yoff
);
    localparam int OFF_W = $clog2(SPR_DIM);
    localparam logic [COORD_W:0] DIM_EXT = (COORD_W+1)'(SPR_DIM);

    // One extra bit so that a sprite hanging off the right/bottom edge
    // (sx + SPR_DIM beyond 2**COORD_W) does not wrap to a small end value.
    logic [COORD_W:0] w_x_ext;
    logic [COORD_W:0] w_y_ext;
    logic [COORD_W:0] w_sx_ext;
    logic [COORD_W:0] w_sy_ext;
    logic             w_in_x;
    logic             w_in_y;

    assign w_x_ext  = {1'b0, i_x};
    assign w_y_ext  = {1'b0, i_y};
    assign w_sx_ext = {1'b0, i_sx};
    assign w_sy_ext = {1'b0, i_sy};

    assign w_in_x = (w_x_ext >= w_sx_ext) && (w_x_ext < (w_sx_ext + DIM_EXT));
    assign w_in_y = (w_y_ext >= w_sy_ext) && (w_y_ext < (w_sy_ext + DIM_EXT));

    assign o_hit  = i_en && w_in_x && w_in_y;
    assign o_xoff = OFF_W'(i_x - i_sx);
    assign o_yoff = OFF_W'(i_y - i_sy);

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// sprite_fetch_scheduler: resolves the palette index of one screen pixel by
// scanning the sprite layers in priority order (layer 0 first), reading the
// sprite BRAM for each layer that covers the pixel, and keeping the first
// non-transparent value.  Fixed 6-cycle latency from pix_start to pix_valid.
// Ports:
//   clk, rst                    clock, async active-high reset
//   pix_start, pix_x, pix_y     pixel request and coordinate
//   cfg_we, cfg_layer, cfg_en,
//   cfg_x, cfg_y                layer configuration write port
//   bram_en, bram_addr          sprite BRAM read request {layer, yoff, xoff}
//   bram_dout                   BRAM data, one cycle after bram_en
//   pix_index, pix_valid        resolved palette index and its strobe
//   busy, overrun               pixel in flight / dropped request pulse
module sprite_fetch_scheduler #(
    parameter int N_LAYERS = sprite_fetch_scheduler_pkg::N_LAYERS,
    parameter int SPR_DIM  = sprite_fetch_scheduler_pkg::SPR_DIM,
    parameter int COORD_W  = sprite_fetch_scheduler_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_start,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_layer,
    input  logic               cfg_en,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    output logic               bram_en,
    output logic [11:0]        bram_addr,
    input  logic [3:0]         bram_dout,
    output logic [3:0]         pix_index,
    output logic               pix_valid,
    output logic               busy,
    output logic               overrun
);
    import sprite_fetch_scheduler_pkg::*;

    localparam int OFF_W = $clog2(SPR_DIM);
    localparam logic [LAYER_W-1:0] K_LAST = LAYER_W'(N_LAYERS - 1);

    logic [1:0]         r_state;
    logic [LAYER_W-1:0] r_k;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    logic               r_cfg_en  [N_LAYERS];
    logic [COORD_W-1:0] r_cfg_x   [N_LAYERS];
    logic [COORD_W-1:0] r_cfg_y   [N_LAYERS];
    logic               r_snap_en [N_LAYERS];
    logic [COORD_W-1:0] r_snap_x  [N_LAYERS];
    logic [COORD_W-1:0] r_snap_y  [N_LAYERS];

    logic               r_rd_pend;
    logic               r_opaque;
    logic [IDX_W-1:0]   r_win;
    logic [IDX_W-1:0]   r_pix_index;
    logic               r_pix_valid;

    logic               w_hit  [N_LAYERS];
    logic [OFF_W-1:0]   w_xoff [N_LAYERS];
    logic [OFF_W-1:0]   w_yoff [N_LAYERS];
    logic               w_sel_hit;
    logic [OFF_W-1:0]   w_sel_xoff;
    logic [OFF_W-1:0]   w_sel_yoff;
    logic               w_bram_en;
    logic               w_take;
    logic [IDX_W-1:0]   w_final;

    genvar g;
    generate
        for (g = 0; g < N_LAYERS; g++) begin : g_hit
            sprite_hit_check #(
                .COORD_W (COORD_W),
                .SPR_DIM (SPR_DIM)
            ) u_hit (
                .i_en   (r_snap_en[g]),
                .i_sx   (r_snap_x[g]),
                .i_sy   (r_snap_y[g]),
                .i_x    (r_x),
                .i_y    (r_y),
                .o_hit  (w_hit[g]),
                .o_xoff (w_xoff[g]),
                .o_yoff (w_yoff[g])
            );
        end
    endgenerate

    // Select the hit result of the layer being scanned this cycle.
    always_comb begin
        w_sel_hit  = 1'b0;
        w_sel_xoff = {OFF_W{1'b0}};
        w_sel_yoff = {OFF_W{1'b0}};
        for (int i = 0; i < N_LAYERS; i++) begin
            w_sel_hit  = w_sel_hit | (w_hit[i] && (r_k == LAYER_W'(i)));
            w_sel_xoff = w_sel_xoff | ((r_k == LAYER_W'(i)) ? w_xoff[i] : {OFF_W{1'b0}});
            w_sel_yoff = w_sel_yoff | ((r_k == LAYER_W'(i)) ? w_yoff[i] : {OFF_W{1'b0}});
        end
    end

    // Once an opaque value is held, later layers cannot change the result,
    // so their reads are suppressed.
    assign w_bram_en = (r_state == ST_SCAN) && w_sel_hit && !r_opaque;
    assign bram_en   = w_bram_en;
    assign bram_addr = w_bram_en ? {r_k, w_sel_yoff, w_sel_xoff} : 12'd0;

    // Data returning this cycle wins only if nothing opaque was captured yet.
    assign w_take  = r_rd_pend && !r_opaque && is_opaque(bram_dout);
    assign w_final = w_take ? bram_dout : r_win;

    assign busy      = (r_state != ST_IDLE);
    assign overrun   = pix_start && busy;
    assign pix_index = r_pix_index;
    assign pix_valid = r_pix_valid;

    // Live layer configuration, writable in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                r_cfg_en[i] <= 1'b0;
                r_cfg_x[i]  <= {COORD_W{1'b0}};
                r_cfg_y[i]  <= {COORD_W{1'b0}};
            end
        end else if (cfg_we && (int'(cfg_layer) < N_LAYERS)) begin
            r_cfg_en[cfg_layer] <= cfg_en;
            r_cfg_x[cfg_layer]  <= cfg_x;
            r_cfg_y[cfg_layer]  <= cfg_y;
        end
    end

    // Pixel FSM: latch request and configuration snapshot, step through layers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k     <= {LAYER_W{1'b0}};
            r_x     <= {COORD_W{1'b0}};
            r_y     <= {COORD_W{1'b0}};
            for (int i = 0; i < N_LAYERS; i++) begin
                r_snap_en[i] <= 1'b0;
                r_snap_x[i]  <= {COORD_W{1'b0}};
                r_snap_y[i]  <= {COORD_W{1'b0}};
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pix_start) begin
                        r_state   <= ST_SCAN;
                        r_k       <= {LAYER_W{1'b0}};
                        r_x       <= pix_x;
                        r_y       <= pix_y;
                        // Non-blocking copy takes pre-write values if cfg_we
                        // coincides with pix_start.
                        r_snap_en <= r_cfg_en;
                        r_snap_x  <= r_cfg_x;
                        r_snap_y  <= r_cfg_y;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (r_k == K_LAST) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                ST_DRAIN: r_state <= ST_OUT;
                ST_OUT:   r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Capture returning BRAM data; first opaque value is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_opaque  <= 1'b0;
            r_win     <= TRANSPARENT_IDX;
        end else begin
            r_rd_pend <= w_bram_en;
            if ((r_state == ST_IDLE) && pix_start) begin
                r_opaque <= 1'b0;
                r_win    <= TRANSPARENT_IDX;
            end else if (w_take) begin
                r_opaque <= 1'b1;
                r_win    <= bram_dout;
            end
        end
    end

    // Registered result: loaded at the end of DRAIN so it appears in OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_index <= TRANSPARENT_IDX;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= (r_state == ST_DRAIN);
            if (r_state == ST_DRAIN) begin
                r_pix_index <= w_final;
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
module tb_sprite_fetch_scheduler;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_start;
    logic [CW-1:0] pix_x, pix_y;
    logic          cfg_we;
    logic [1:0]    cfg_layer;
    logic          cfg_en;
    logic [CW-1:0] cfg_x, cfg_y;
    logic          bram_en;
    logic [11:0]   bram_addr;
    logic [3:0]    bram_dout = 4'd0;
    logic [3:0]    pix_index;
    logic          pix_valid;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    sprite_fetch_scheduler dut (
        .clk(clk), .rst(rst), .pix_start(pix_start), .pix_x(pix_x), .pix_y(pix_y),
        .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .pix_index(pix_index), .pix_valid(pix_valid), .busy(busy), .overrun(overrun)
    );

    // Sprite BRAM model: one-cycle read latency.
    logic [3:0] mem [0:4095];
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int idx; int t0; int reads; } exp_t;
    typedef struct {
        bit do_cfg; int layer; bit en; int cx; int cy;
        bit do_pix; int px; int py; int exp_idx; int exp_reads;
    } vec_t;

    exp_t sb_q[$];
    int   addr_q[$];
    vec_t tbl[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   reads_cnt = 0;
    int   last_exp = 0;
    bit   sh_en [4];
    int   sh_x  [4];
    int   sh_y  [4];

    task automatic check(input bit ok, input string name, input int act, input int exp_v);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) tick();
    endtask

    // Reference: layers in priority order, stop after the first opaque read.
    task automatic model_push(input int px, input int py);
        for (int k = 0; k < 4; k++) begin
            if (sh_en[k] && px >= sh_x[k] && px < sh_x[k] + 32 &&
                py >= sh_y[k] && py < sh_y[k] + 32) begin
                int a;
                a = k * 1024 + (py - sh_y[k]) * 32 + (px - sh_x[k]);
                addr_q.push_back(a);
                if (mem[a] != 4'd0) break;
            end
        end
    endtask

    task automatic start_pix(input int px, input int py, input int idx, input int reads, input bit push_sb);
        exp_t e;
        model_push(px, py);
        e.idx = idx; e.t0 = cyc; e.reads = reads;
        if (push_sb) sb_q.push_back(e);
        pix_start = 1'b1; pix_x = CW'(px); pix_y = CW'(py);
        tick();
        pix_start = 1'b0;
    endtask

    task automatic cfg(input int layer, input bit en, input int x, input int y);
        cfg_we = 1'b1; cfg_layer = 2'(layer); cfg_en = en; cfg_x = CW'(x); cfg_y = CW'(y);
        tick();
        cfg_we = 1'b0;
        sh_en[layer] = en; sh_x[layer] = x; sh_y[layer] = y;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check(sb_q.size() == 0, "pix_valid_timeout", sb_q.size(), 0);
        tick();
    endtask

    task automatic check_all_zero(input string name);
        check({bram_en, bram_addr, pix_index, pix_valid, busy, overrun} == 20'd0, name,
              int'({bram_en, bram_addr, pix_index, pix_valid, busy, overrun}), 0);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                reads_cnt = 0;
                addr_q.delete();
                last_exp = 0;
            end else begin
                if (bram_en) begin
                    reads_cnt++;
                    if (addr_q.size() == 0) check(1'b0, "bram_unexpected", int'(bram_addr), -1);
                    else begin
                        int a;
                        a = addr_q.pop_front();
                        check(int'(bram_addr) == a, "bram_addr", int'(bram_addr), a);
                    end
                end
                if (pix_valid) begin
                    if (sb_q.size() == 0) check(1'b0, "pix_valid_unexpected", 1, 0);
                    else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check(int'(pix_index) == e.idx, "pix_index", int'(pix_index), e.idx);
                        check(cyc - e.t0 == 6, "latency", cyc - e.t0, 6);
                        check(reads_cnt == e.reads, "read_count", reads_cnt, e.reads);
                        last_exp = e.idx;
                    end
                    reads_cnt = 0;
                end else begin
                    check(int'(pix_index) == last_exp, "pix_index_hold", int'(pix_index), last_exp);
                end
            end
        end
    endtask

    initial begin
        int t0;
        for (int i = 0; i < 4096; i++) mem[i] = 4'd0;
        mem[330]  = 4'd3;   // L0 {0,10,10}
        mem[2378] = 4'd6;   // L2 {2,10,10}
        mem[495]  = 4'd7;   // L0 {0,15,15}
        mem[2213] = 4'd12;  // L2 {2,5,5}
        mem[1363] = 4'd9;   // L1 {1,10,19}
        mem[1367] = 4'd5;   // L1 {1,10,23}
        mem[4064] = 4'd2;   // L3 {3,31,0}
        for (int k = 0; k < 4; k++) begin sh_en[k] = 1'b0; sh_x[k] = 0; sh_y[k] = 0; end

        rst = 1'b1; pix_start = 1'b0; pix_x = '0; pix_y = '0;
        cfg_we = 1'b0; cfg_layer = 2'd0; cfg_en = 1'b0; cfg_x = '0; cfg_y = '0;
        fork
            monitor();
        join_none
        repeat (2) tick();
        check_all_zero("reset_outputs");
        rst = 1'b0;
        tick();

        //             cfg  L  en  cx    cy   pix  px    py   idx rd
        tbl.push_back('{1, 0, 1, 100,  50,  0,   0,   0,  0, 0});
        tbl.push_back('{0, 0, 0,   0,   0,  1, 110,  60,  3, 1});
        tbl.push_back('{1, 1, 1, 620, 300,  0,   0,   0,  0, 0});
        tbl.push_back('{0, 0, 0,   0,   0,  1, 639, 310,  9, 1});
        tbl.push_back('{0, 0, 0,   0,   0,  1, 652, 310,  0, 0});
        tbl.push_back('{1, 0, 1, 180, 180,  0,   0,   0,  0, 0});
        tbl.push_back('{1, 2, 1, 190, 190,  0,   0,   0,  0, 0});
        tbl.push_back('{0, 0, 0,   0,   0,  1, 200, 200,  6, 2});
        tbl.push_back('{0, 0, 0,   0,   0,  1, 195, 195,  7, 1});
        tbl.push_back('{1, 1, 1,1000, 300,  0,   0,   0,  0, 0});
        tbl.push_back('{0, 0, 0,   0,   0,  1,1023, 310,  5, 1});
        tbl.push_back('{1, 3, 1,  40,  40,  0,   0,   0,  0, 0});
        tbl.push_back('{0, 0, 0,   0,   0,  1,  40,  71,  2, 1});
        tbl.push_back('{0, 0, 0,   0,   0,  1,  39,  50,  0, 0});
        tbl.push_back('{0, 0, 0,   0,   0,  1,  40,  72,  0, 0});
        tbl.push_back('{1, 0, 0,   0,   0,  0,   0,   0,  0, 0});
        tbl.push_back('{1, 1, 0,   0,   0,  0,   0,   0,  0, 0});
        tbl.push_back('{1, 2, 0,   0,   0,  0,   0,   0,  0, 0});
        tbl.push_back('{1, 3, 0,   0,   0,  0,   0,   0,  0, 0});
        tbl.push_back('{0, 0, 0,   0,   0,  1, 200, 200,  0, 0});
        foreach (tbl[i]) begin
            if (tbl[i].do_cfg) cfg(tbl[i].layer, tbl[i].en, tbl[i].cx, tbl[i].cy);
            if (tbl[i].do_pix) begin
                start_pix(tbl[i].px, tbl[i].py, tbl[i].exp_idx, tbl[i].exp_reads, 1'b1);
                wait_idle();
            end
        end

        // Overrun while scanning and in the OUT cycle; pixel in flight unaffected.
        cfg(0, 1'b1, 100, 50);
        t0 = cyc;
        start_pix(110, 60, 3, 1, 1'b1);
        goto_cycle(t0 + 3);
        pix_start = 1'b1; pix_x = 10'd0; pix_y = 10'd0;
        #3;
        check(overrun == 1'b1, "overrun_scan", int'(overrun), 1);
        check(busy == 1'b1, "busy_scan", int'(busy), 1);
        tick();
        pix_start = 1'b0;
        #3;
        check(overrun == 1'b0, "overrun_single", int'(overrun), 0);
        goto_cycle(t0 + 6);
        pix_start = 1'b1;
        #3;
        check(overrun == 1'b1, "overrun_out", int'(overrun), 1);
        tick();
        pix_start = 1'b0;
        #3;
        check(busy == 1'b0, "idle_after_out", int'(busy), 0);
        wait_idle();
        repeat (8) tick();

        // cfg_we together with pix_start: snapshot keeps the pre-write enable.
        model_push(110, 60);
        sb_q.push_back('{3, cyc, 1});
        cfg_we = 1'b1; cfg_layer = 2'd0; cfg_en = 1'b0; cfg_x = 10'd100; cfg_y = 10'd50;
        pix_start = 1'b1; pix_x = 10'd110; pix_y = 10'd60;
        tick();
        cfg_we = 1'b0; pix_start = 1'b0;
        sh_en[0] = 1'b0;
        wait_idle();
        // Live write during flight does not affect that pixel, but the next one.
        start_pix(110, 60, 0, 0, 1'b1);
        cfg(0, 1'b1, 100, 50);
        wait_idle();
        start_pix(110, 60, 3, 1, 1'b1);
        wait_idle();

        // Reset mid-pixel: outputs cleared at once, no pix_valid, config cleared.
        t0 = cyc;
        start_pix(110, 60, 3, 1, 1'b0);
        goto_cycle(t0 + 3);
        rst = 1'b1;
        #1;
        check_all_zero("reset_midpixel");
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin sh_en[k] = 1'b0; sh_x[k] = 0; sh_y[k] = 0; end
        repeat (10) tick();
        start_pix(110, 60, 0, 0, 1'b1);
        wait_idle();
        repeat (3) tick();
        check(addr_q.size() == 0, "bram_reads_missing", addr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
